// File: rtl/delay_reg_pkg.sv
// delay_reg_pkg: shared helpers for the variable delay register (clamp, fill width)
package delay_reg_pkg;
  function automatic int clamp_le(input logic [31:0] pos, input int depth);
    return (pos < 32'd1) ? 1 : (pos > 32'(depth)) ? depth : int'(pos);
  endfunction
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one chain stage with enable, insertion mux, flush and collision detect
module delay_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             ins,
  input  logic [WIDTH-1:0] shift_data,
  input  logic             shift_valid,
  input  logic [WIDTH-1:0] ins_data,
  input  logic             ins_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             coll
);
  // a live beat arriving from upstream is lost when this stage is the insertion point
  assign coll = en & ins & shift_valid & ~flush;
  // take the inserted beat or the shifted one; flush kills only shifted valids
  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      data  <= ins ? ins_data : shift_data;
      valid <= ins ? ins_valid : shift_valid & ~flush;
    end
  end
endmodule

// File: rtl/delay_reg_var.sv
// delay_reg_var: variable-depth delay chain with valid tagging; DELAY_REG_BYPASS_EN enables in_pos==0 bypass
module delay_reg_var
  import delay_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int POS_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         valid_in,
  input  logic [POS_W-1:0]             in_pos,
  output logic [WIDTH-1:0]             data_out,
  output logic                         valid_out,
  output logic [fill_w(DEPTH)-1:0]     fill,
  output logic                         drop_err
);
  localparam int FILL_W = fill_w(DEPTH);
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v, ins, coll;
  logic             bypass;
  int               le;
`ifdef DELAY_REG_BYPASS_EN
  assign bypass    = in_pos == '0;
  assign data_out  = bypass ? data_in : d[DEPTH-1];
  assign valid_out = bypass ? valid_in : v[DEPTH-1];
`else
  assign bypass    = 1'b0;
  assign data_out  = d[DEPTH-1];
  assign valid_out = v[DEPTH-1];
`endif
  // one-hot insertion point k = DEPTH - Le, suppressed in bypass
  always_comb begin
    le = clamp_le(32'(in_pos), DEPTH);
    for (int i = 0; i < DEPTH; i++) ins[i] = !bypass && (i == DEPTH - le);
  end
  // occupancy is the popcount of stage valids
  always_comb begin
    fill = '0;
    for (int i = 0; i < DEPTH; i++) fill = fill + FILL_W'(v[i]);
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] sd;
    logic             sv;
    if (i == 0) begin : g_head
      assign sd = '0;
      assign sv = 1'b0;
    end else begin : g_tail
      assign sd = d[i-1];
      assign sv = v[i-1];
    end
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .ins(ins[i]),
      .shift_data(sd), .shift_valid(sv), .ins_data(data_in), .ins_valid(valid_in),
      .data(d[i]), .valid(v[i]), .coll(coll[i])
    );
  end
  // sticky overwrite flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) drop_err <= 1'b0;
    else if (|coll) drop_err <= 1'b1;
  end
endmodule

// File: tb/tb_delay_reg_var.sv
// tb_delay_reg_var: randomized and directed checks of delay_reg_var against a beat-list model
module tb_delay_reg_var;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic [7:0]  in_pos = 8'd4;
  logic [31:0] data_out;
  logic        valid_out;
  logic [2:0]  fill;
  logic        drop_err;
  int          vectors = 0;
  int          errors = 0;
  typedef struct {
    logic [31:0] d;
    int          rem;
  } beat_t;
  beat_t q[$];
  bit    m_err;

  delay_reg_var #(.DEPTH(DEPTH), .WIDTH(32), .POS_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .data_in(data_in),
    .valid_in(valid_in), .in_pos(in_pos), .data_out(data_out),
    .valid_out(valid_out), .fill(fill), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int pos);
    bit          exp_v = 0;
    logic [31:0] exp_d = '0;
    bit          byp = 0;
`ifdef DELAY_REG_BYPASS_EN
    byp = (pos == 0);
`endif
    foreach (q[j]) if (q[j].rem == 0) begin exp_v = 1; exp_d = q[j].d; end
    if (byp) begin exp_v = valid_in; exp_d = data_in; end
    vectors++;
    if (valid_out !== exp_v) begin errors++; $display("FAIL %s valid_out got %b want %b", name, valid_out, exp_v); end
    if (exp_v) begin
      vectors++;
      if (data_out !== exp_d) begin errors++; $display("FAIL %s data_out got %h want %h", name, data_out, exp_d); end
    end
    vectors++;
    if (fill !== 3'(q.size())) begin errors++; $display("FAIL %s fill got %0d want %0d", name, fill, q.size()); end
    vectors++;
    if (drop_err !== m_err) begin errors++; $display("FAIL %s drop_err got %b want %b", name, drop_err, m_err); end
  endtask

  task automatic step(input string name, input bit e, input bit f, input bit vi, input logic [31:0] di, input int pos);
    beat_t keep[$];
    bit    byp = 0;
    int    le;
    en = e; flush = f; valid_in = vi; data_in = di; in_pos = 8'(pos);
    @(posedge clk);
`ifdef DELAY_REG_BYPASS_EN
    byp = (pos == 0);
`endif
    le = pos < 1 ? 1 : pos > DEPTH ? DEPTH : pos;
    if (e) begin
      keep = {};
      if (!f) foreach (q[j]) if (q[j].rem > 0) keep.push_back('{q[j].d, q[j].rem - 1});
      q = keep;
      if (!byp) begin
        for (int j = 0; j < q.size(); j++)
          if (q[j].rem == le - 1) begin q.delete(j); m_err = 1; break; end
        if (vi) q.push_back('{di, le - 1});
      end
    end
    #1;
    check(name, pos);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0; en = 1'b1; flush = 1'b1; valid_in = 1'b1; data_in = 32'hdead_beef;
    @(posedge clk);
    #1;
    q = {}; m_err = 0;
    vectors++;
    if (data_out !== '0 || valid_out !== 1'b0 || fill !== '0 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL %s got d=%h v=%b fill=%0d err=%b want all zero", name, data_out, valid_out, fill, drop_err);
    end
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_in_order();
    for (int i = 1; i <= 6; i++) step("in_order", 1, 0, 1, 32'(i), 4);
    for (int i = 0; i < 5; i++) step("in_order_drain", 1, 0, 0, 32'hffff, 4);
  endtask

  task automatic test_clamp();
    step("pos1", 1, 0, 1, 32'ha5, 1);
    step("pos1_idle", 1, 0, 0, 0, 1);
    step("pos9", 1, 0, 1, 32'h99, 9);
    for (int i = 0; i < 4; i++) step("pos9_drain", 1, 0, 0, 0, 9);
    step("pos0", 1, 0, 1, 32'h5a, 0);
    step("pos0_idle", 1, 0, 0, 0, 1);
  endtask

  task automatic test_collision();
    do_reset("coll_reset");
    for (int i = 1; i <= 3; i++) step("coll_fill", 1, 0, 1, 32'h100 + 32'(i), 4);
    step("coll_hit", 1, 0, 1, 32'h200, 2);
    for (int i = 0; i < 5; i++) step("coll_drain", 1, 0, 0, 0, 4);
  endtask

  task automatic test_hold();
    do_reset("hold_reset");
    step("hold_in", 1, 0, 1, 32'h11, 2);
    step("hold_0a", 0, 1, 1, 32'h22, 4);
    step("hold_0b", 0, 0, 1, 32'h33, 1);
    step("hold_out", 1, 0, 0, 0, 2);
    step("hold_drain", 1, 0, 0, 0, 2);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step("flush_fill", 1, 0, 1, 32'h40 + 32'(i), 1 + (i % 2) * 3);
    step("flush_hit", 1, 1, 1, 32'h77, 4);
    for (int i = 0; i < 4; i++) step("flush_drain", 1, 0, 0, 0, 4);
    step("mid_a", 1, 0, 1, 32'h55, 2);
    step("mid_b", 1, 0, 1, 32'h66, 3);
    do_reset("reset_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step("random", $urandom_range(3) != 0, $urandom_range(19) == 0, $urandom_range(1) == 1,
           $urandom, int'($urandom_range(6)));
  endtask

  initial begin
    m_err = 0;
    test_reset();
    test_in_order();
    test_clamp();
    test_collision();
    test_hold();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
